data_mem_resp: RTL
==================

# data_mem_resp

Memory-side responder for the core's load/store handshake. Accepts load and store requests with RISC-V `funct3` access size and address, and holds a word-organised data memory. After a configurable latency, returns sign- or zero-extended load data with a one-cycle `mem_read_data_valid` pulse, or commits store bytes with a one-cycle `mem_write_ready` pulse. It is the producer of the two signals the decode stage waits on while stalling loads and S-type instructions.

## Interface
- `DEPTH_WORDS`, 1024 — number of 32-bit words; power of two.
- `READ_LATENCY`, 2 — cycles from load acceptance to valid; ≥1.
- `WRITE_LATENCY`, 1 — cycles from store acceptance to ready; ≥1.
- `clk`  in  1  — single clock, rising edge.
- `reset`  in  1  — asynchronous, active-high.
- `mem_read_req`  in  1  — load pending; held stable until `mem_read_data_valid`.
- `mem_write_req`  in  1  — store pending; held stable until `mem_write_ready`.
- `funct3`  in  3  — access size and sign, per RV32I load/store encoding.
- `addr`  in  32  — byte address.
- `write_data`  in  32  — store data, right-aligned.
- `read_data`  out  32  — extended load result; valid only with `mem_read_data_valid`.
- `mem_read_data_valid`  out  1  — one-cycle load completion pulse.
- `mem_write_ready`  out  1  — one-cycle store completion pulse.
- `misalign_err`  out  1  — one-cycle pulse replacing the completion pulse of a misaligned access.

## Operation
- FSM states: `IDLE`, `RBUSY`, `RRESP`, `WBUSY`, `WRESP`.
- **IDLE:** if `mem_read_req`, capture `addr` and `funct3`, load the counter, and go to `RBUSY`. Else if `mem_write_req`, also capture `write_data` and go to `WBUSY`.
  - Read has priority when both requests are high; the write is taken only after the read completes.
- **RBUSY/WBUSY:** decrement the counter. At terminal count go to `RRESP`/`WRESP`. With latency 1, go straight from `IDLE` to the `*RESP` state.
- **RRESP:** `mem_read_data_valid`=1 and `read_data` driven for one cycle, then `IDLE`.
- **WRESP:** `mem_write_ready`=1 for one cycle. Byte lanes are written at the closing edge of this cycle, then `IDLE`.
- Each pulse ends exactly one transaction. A request still high in the cycle after a pulse is a new, back-to-back access.
- Word index is `addr[log2(DEPTH_WORDS)+1:2]`. Upper address bits are ignored, so addresses wrap modulo memory size.
- **Loads:**
  - `000` LB: sign-extend byte `addr[1:0]`.
  - `100` LBU: zero-extend byte `addr[1:0]`.
  - `001` LH: sign-extend halfword `addr[1]`.
  - `101` LHU: zero-extend halfword `addr[1]`.
  - `010` LW: full word.
  - Reserved codes: treated as LW.
- **Stores:**
  - `000` SB: byte enable `1<<addr[1:0]`, data replicated across lanes.
  - `001` SH: enable `0011`/`1100` per `addr[1]`.
  - `010` SW and reserved codes: enable `1111`.
- **Reset:**
  - All outputs are 0, FSM in `IDLE`, counter cleared.
  - A reset mid-transaction aborts it: no pulse, and no memory write.
  - Memory contents are not reset.

## Timing
- A request first seen in `IDLE` in cycle N gets its pulse in cycle N+`READ_LATENCY` (or N+`WRITE_LATENCY`).
- Minimum load-to-load spacing is `READ_LATENCY`+1 cycles.
- A store followed by a load to the same address returns the new data. The write commits before the load can be accepted.
- `read_data` is registered. It is 0 outside `RRESP`.
- Requests arriving during `*BUSY`/`*RESP` are ignored until `IDLE`.

## Configuration
- `MISALIGN_TRAP_EN`
  - **Defined:** a halfword with `addr[0]`=1, or a word with `addr[1:0]`≠0, still runs the full latency. The final cycle pulses `misalign_err` instead of valid/ready. No memory write occurs, and `read_data` stays 0.
  - **Undefined:** `misalign_err` is tied 0. Low address bits are forced aligned: bit 0 is ignored for halfwords, bits 1:0 for words.

## Structure
- Package `mem_pkg`:
  - `funct3` load/store constants.
  - FSM state enum.
  - `word_t` (32-bit) typedef.
  - Byte-enable function.
- Sub-module `load_align`: combinational extraction and extension of the addressed byte or halfword from a 32-bit word, keyed by `funct3` and `addr[1:0]`.
- Memory is an inferred array with byte-enable write in the top module.

## Test plan
- Reset, then SW `addr`=0x10, data 0xDEADBEEF, `WRITE_LATENCY`=1 → `mem_write_ready` pulses 1 cycle after the request. LW 0x10 → `read_data`=0xDEADBEEF exactly `READ_LATENCY` cycles later, single pulse.
- From that word: LB 0x13 → 0xFFFFFFDE; LBU 0x13 → 0x000000DE; LH 0x12 → 0xFFFFDEAD; LHU 0x10 → 0x0000BEEF.
- SB 0x11 data 0x55, then LW 0x10 → 0xDEAD55EF. SH 0x12 data 0x1234, then LW → 0x123455EF.
- Back-to-back loads with `mem_read_req` held high → two separate valid pulses, `READ_LATENCY`+1 cycles apart. Read and write requests both high → read completes first.
- Reset asserted during `WBUSY` of SW 0x20 data 0xFFFFFFFF → no ready pulse. A later LW 0x20 returns the prior contents.
- With `MISALIGN_TRAP_EN`, LW 0x11 → `misalign_err` pulse, no valid. Without it → data from 0x10, valid pulse.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared types and helpers for the load/store memory responder: funct3 codes,
// FSM states, access sizing, alignment and store lane formatting.
package mem_pkg;

  typedef logic [31:0] word_t;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    RBUSY = 3'd1,
    RRESP = 3'd2,
    WBUSY = 3'd3,
    WRESP = 3'd4
  } state_t;

  // Access size as log2(bytes): 0 byte, 1 halfword, 2 word.
  function automatic logic [1:0] ld_size(input logic [2:0] f3);
    case (f3)
      F3_B, F3_BU: ld_size = 2'd0;
      F3_H, F3_HU: ld_size = 2'd1;
      default:     ld_size = 2'd2;
    endcase
  endfunction

  function automatic logic [1:0] st_size(input logic [2:0] f3);
    case (f3)
      F3_B:    st_size = 2'd0;
      F3_H:    st_size = 2'd1;
      default: st_size = 2'd2;
    endcase
  endfunction

  function automatic logic misaligned(input logic [1:0] sz, input logic [1:0] lo);
    misaligned = ((sz == 2'd1) && lo[0]) || ((sz == 2'd2) && (lo != 2'b00));
  endfunction

  function automatic logic [1:0] align_lo(input logic [1:0] sz, input logic [1:0] lo);
    case (sz)
      2'd0:    align_lo = lo;
      2'd1:    align_lo = {lo[1], 1'b0};
      default: align_lo = 2'b00;
    endcase
  endfunction

  function automatic logic [3:0] byte_en(input logic [2:0] f3, input logic [1:0] lo);
    case (f3)
      F3_B:    byte_en = 4'b0001 << lo;
      F3_H:    byte_en = lo[1] ? 4'b1100 : 4'b0011;
      default: byte_en = 4'b1111;
    endcase
  endfunction

  function automatic word_t store_rep(input logic [2:0] f3, input word_t wd);
    case (f3)
      F3_B:    store_rep = {4{wd[7:0]}};
      F3_H:    store_rep = {2{wd[15:0]}};
      default: store_rep = wd;
    endcase
  endfunction

endpackage

// File: rtl/load_align.sv
// Combinational load formatter: picks the addressed byte/halfword from a word
// and sign- or zero-extends it; reserved funct3 codes return the full word.
module load_align
  import mem_pkg::*;
(
  input  word_t       word_i,
  input  logic [2:0]  funct3_i,
  input  logic [1:0]  addr_lo_i,
  output word_t       data_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = 8'(word_i >> {addr_lo_i, 3'b000});
    half_sel = addr_lo_i[1] ? word_i[31:16] : word_i[15:0];
    case (funct3_i)
      F3_B:    data_o = {{24{byte_sel[7]}}, byte_sel};
      F3_BU:   data_o = {24'h0, byte_sel};
      F3_H:    data_o = {{16{half_sel[15]}}, half_sel};
      F3_HU:   data_o = {16'h0, half_sel};
      default: data_o = word_i;
    endcase
  end

endmodule

// File: rtl/data_mem_resp.sv
// Load/store responder: one request at a time, pulse after READ_/WRITE_LATENCY cycles, others ignored until IDLE.
// MISALIGN_TRAP_EN: misaligned halfword/word accesses pulse misalign_err instead of completing.
module data_mem_resp
  import mem_pkg::*;
#(
  parameter int DEPTH_WORDS   = 1024,
  parameter int READ_LATENCY  = 2,
  parameter int WRITE_LATENCY = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mem_read_req,
  input  logic        mem_write_req,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] write_data,
  output logic [31:0] read_data,
  output logic        mem_read_data_valid,
  output logic        mem_write_ready,
  output logic        misalign_err
);

  localparam int AW = $clog2(DEPTH_WORDS);
  localparam int CW = 16;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    f3_q, f3_d;
  logic [AW+1:0] addr_q, addr_d;
  word_t         wdata_q, wdata_d;
  logic          mis_q, mis_d;
  word_t         rdata_q, rdata_d;

  word_t         mem [DEPTH_WORDS];
  word_t         rd_word, ld_val, st_word;
  logic [3:0]    st_be;
  logic [1:0]    acc_sz;
  logic          unused_addr;

  assign unused_addr = ^addr[31:AW+2];
  assign acc_sz      = mem_read_req ? ld_size(funct3) : st_size(funct3);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    f3_d    = f3_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    mis_d   = mis_q;
    case (state_q)
      IDLE: begin
        if (mem_read_req || mem_write_req) begin
          f3_d = funct3;
`ifdef MISALIGN_TRAP_EN
          addr_d = addr[AW+1:0];
          mis_d  = misaligned(acc_sz, addr[1:0]);
`else
          addr_d = {addr[AW+1:2], align_lo(acc_sz, addr[1:0])};
          mis_d  = 1'b0;
`endif
          if (mem_read_req) begin
            if (READ_LATENCY == 1) begin
              state_d = RRESP;
            end else begin
              state_d = RBUSY;
              cnt_d   = CW'(READ_LATENCY - 2);
            end
          end else begin
            wdata_d = write_data;
            if (WRITE_LATENCY == 1) begin
              state_d = WRESP;
            end else begin
              state_d = WBUSY;
              cnt_d   = CW'(WRITE_LATENCY - 2);
            end
          end
        end
      end
      RBUSY: begin
        if (cnt_q == '0) state_d = RRESP;
        else             cnt_d   = cnt_q - CW'(1);
      end
      WBUSY: begin
        if (cnt_q == '0) state_d = WRESP;
        else             cnt_d   = cnt_q - CW'(1);
      end
      default: state_d = IDLE;
    endcase
  end

  // Load data is formatted on the way into RRESP so read_data leaves a register.
  assign rd_word = mem[addr_d[AW+1:2]];

  load_align u_align (
    .word_i    (rd_word),
    .funct3_i  (f3_d),
    .addr_lo_i (addr_d[1:0]),
    .data_o    (ld_val)
  );

  always_comb begin
    rdata_d = '0;
    if (state_d == RRESP && !mis_d) rdata_d = ld_val;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      f3_q    <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      mis_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      f3_q    <= f3_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      mis_q   <= mis_d;
      rdata_q <= rdata_d;
    end
  end

  assign st_be   = byte_en(f3_q, addr_q[1:0]);
  assign st_word = store_rep(f3_q, wdata_q);

  // Stores commit on the edge closing WRESP; a reset before then leaves memory untouched.
  always_ff @(posedge clk) begin
    if (state_q == WRESP && !mis_q) begin
      for (int i = 0; i < 4; i++) begin
        if (st_be[i]) mem[addr_q[AW+1:2]][8*i +: 8] <= st_word[8*i +: 8];
      end
    end
  end

  assign read_data           = rdata_q;
  assign mem_read_data_valid = (state_q == RRESP) && !mis_q;
  assign mem_write_ready     = (state_q == WRESP) && !mis_q;
`ifdef MISALIGN_TRAP_EN
  assign misalign_err = ((state_q == RRESP) || (state_q == WRESP)) && mis_q;
`else
  assign misalign_err = 1'b0;
`endif

endmodule
